// File: rtl/redmule_tiler_mp_if.sv
// redmule_tiler_mp_if: job request and tiling-result bundle between regfile/controller and the tiler.
// The slave modport is the tiler side; the master modport is the job issuer / result consumer.
interface redmule_tiler_mp_if;
  logic [15:0]  m_size_i;
  logic [15:0]  n_size_i;
  logic [15:0]  k_size_i;
  logic [2:0]   fmt_i;
  logic         start_valid_i;
  logic         start_ready_o;
  logic [63:0]  iters_o;
  logic [31:0]  lftovr_o;
  logic [15:0]  x_slots_o;
  logic [95:0]  strides_o;
  logic [111:0] totals_o;
  logic         valid_o;
  logic         ready_i;
  logic         err_o;

  modport slave (
    input  m_size_i, n_size_i, k_size_i, fmt_i, start_valid_i, ready_i,
    output start_ready_o, iters_o, lftovr_o, x_slots_o, strides_o, totals_o, valid_o, err_o
  );

  modport master (
    output m_size_i, n_size_i, k_size_i, fmt_i, start_valid_i, ready_i,
    input  start_ready_o, iters_o, lftovr_o, x_slots_o, strides_o, totals_o, valid_o, err_o
  );
endinterface

// File: rtl/redmule_tiler_mp.sv
// redmule_tiler_mp: multi-precision GEMM tiler using one shared 16-step shift-add multiplier.
// Optional size/overflow checking on err_o is enabled by defining REDMULE_TILER_ERR_EN.
module redmule_tiler_mp #(
  parameter int unsigned ARRAY_WIDTH  = 12,
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned PIPE_REGS    = 3,
  parameter int unsigned DATAW        = 288
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic               clear_i,
  redmule_tiler_mp_if.slave bus
);
  localparam logic [15:0] AW      = 16'(ARRAY_WIDTH);
  localparam logic [15:0] AH      = 16'(ARRAY_HEIGHT);
  localparam logic [15:0] D       = 16'(ARRAY_HEIGHT * (PIPE_REGS + 1));
  localparam logic [15:0] SLOTS16 = 16'(DATAW / (ARRAY_HEIGHT * 16));
  localparam logic [15:0] SLOTS8  = 16'(DATAW / (ARRAY_HEIGHT * 8));
`ifdef REDMULE_TILER_ERR_EN
  localparam int unsigned ACCW = 48;
`else
  localparam int unsigned ACCW = 32;
`endif

  typedef enum logic [2:0] {
    FMT_FP32 = 3'd0, FMT_FP64 = 3'd1, FMT_FP16 = 3'd2,
    FMT_FP8  = 3'd3, FMT_FP16ALT = 3'd4, FMT_FP8ALT = 3'd5
  } gemm_fmt_e;

  typedef enum logic [2:0] {IDLE, LATCH, MUL1, MUL2, MUL3, DONE} state_e;

  state_e state_q, state_d;

  logic [63:0]     iters_q;
  logic [31:0]     lftovr_q;
  logic [15:0]     x_slots_q;
  logic [95:0]     strides_q;
  logic [111:0]    totals_q;
  logic [31:0]     p1_q, p2_q;
  logic [ACCW-1:0] acc_q, acc_sum;
  logic [3:0]      cnt_q;

  logic        accept, mul_busy, mul_last;
  logic [15:0] mul_a;
  logic [31:0] mul_b;

  // Job decode from the request inputs; captured on the accept edge.
  logic        bitw8;
  logic [15:0] xr, xc, wc, xr_it, xc_it, wc_it, wr_it, slots;
  logic [7:0]  xr_l, xc_l, wc_l, wr_l;
  logic [31:0] x_d1, w_d0;

  always_comb begin
    bitw8 = (bus.fmt_i == FMT_FP8) || (bus.fmt_i == FMT_FP8ALT);
    xr    = bus.m_size_i / AW;
    xc    = bus.n_size_i / D;
    wc    = bus.k_size_i / D;
    xr_l  = 8'(bus.m_size_i - xr * AW);
    xc_l  = 8'(bus.n_size_i - xc * D);
    wc_l  = 8'(bus.k_size_i - wc * D);
    wr_l  = 8'(bus.n_size_i - (bus.n_size_i / AH) * AH);
    xr_it = xr + {15'b0, xr_l != 8'd0};
    xc_it = xc + {15'b0, xc_l != 8'd0};
    wc_it = wc + {15'b0, wc_l != 8'd0};
    wr_it = (wr_l != 8'd0) ? bus.n_size_i + (AH - {8'b0, wr_l}) : bus.n_size_i;
    slots = bitw8 ? ({8'b0, xc_l} + SLOTS8 - 16'd1) / SLOTS8
                  : ({8'b0, xc_l} + SLOTS16 - 16'd1) / SLOTS16;
    x_d1  = bitw8 ? {16'b0, bus.n_size_i} : {15'b0, bus.n_size_i, 1'b0};
    w_d0  = bitw8 ? {16'b0, bus.k_size_i} : {15'b0, bus.k_size_i, 1'b0};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mul_busy = 1'b0;
    mul_a    = '0;
    mul_b    = '0;
    unique case (state_q)
      IDLE: if (bus.start_valid_i) begin
        accept  = 1'b1;
        state_d = LATCH;
      end
      LATCH: state_d = MUL1;
      MUL1: begin
        mul_busy = 1'b1;
        mul_a    = iters_q[63:48];
        mul_b    = {16'b0, iters_q[15:0]};
        if (cnt_q == 4'd15) state_d = MUL2;
      end
      MUL2: begin
        mul_busy = 1'b1;
        mul_a    = iters_q[47:32];
        mul_b    = p1_q;
        if (cnt_q == 4'd15) state_d = MUL3;
      end
      MUL3: begin
        mul_busy = 1'b1;
        mul_a    = iters_q[31:16];
        mul_b    = p1_q;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mul_last = mul_busy && (cnt_q == 4'd15);
    acc_sum  = acc_q + (mul_a[cnt_q] ? (ACCW'(mul_b) << cnt_q) : '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      iters_q   <= '0;
      lftovr_q  <= '0;
      x_slots_q <= '0;
      strides_q <= '0;
      totals_q  <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        iters_q   <= {xr_it, xc_it, wr_it, wc_it};
        lftovr_q  <= {xr_l, xc_l, wr_l, wc_l};
        x_slots_q <= slots;
        strides_q <= {x_d1, w_d0, 32'(w_d0 * {16'b0, AW})};
      end
      // The counter wraps to 0 on the last step, so each product starts clean.
      if (mul_busy) begin
        cnt_q <= cnt_q + 4'd1;
        acc_q <= mul_last ? '0 : acc_sum;
      end
      if (mul_last) begin
        unique case (state_q)
          MUL1: p1_q <= acc_sum[31:0];
          MUL2: p2_q <= acc_sum[31:0];
          MUL3: totals_q <= {p1_q[15:0], p2_q, acc_sum[31:0], 32'(p1_q * {16'b0, AW})};
          default: ;
        endcase
      end
    end
  end

`ifdef REDMULE_TILER_ERR_EN
  logic zero_q, ovf_q, big_q, lft_big;

  always_comb begin
    lft_big = (16'(bus.m_size_i - xr * AW) > 16'd255) ||
              (16'(bus.n_size_i - xc * D)  > 16'd255) ||
              (16'(bus.k_size_i - wc * D)  > 16'd255);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      big_q  <= 1'b0;
    end else if (accept) begin
      zero_q <= (bus.m_size_i == '0) || (bus.n_size_i == '0) || (bus.k_size_i == '0);
      big_q  <= lft_big;
      ovf_q  <= 1'b0;
    end else if (mul_last && (|acc_sum[ACCW-1:32])) begin
      ovf_q  <= 1'b1;
    end
  end

  assign bus.err_o = (state_q == DONE) && (zero_q || ovf_q || big_q);
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.start_ready_o = (state_q == IDLE);
  assign bus.valid_o       = (state_q == DONE);
  assign bus.iters_o       = iters_q;
  assign bus.lftovr_o      = lftovr_q;
  assign bus.x_slots_o     = x_slots_q;
  assign bus.strides_o     = strides_q;
  assign bus.totals_o      = totals_q;
endmodule
